// File: rtl/reg_dump_streamer_if.sv
// Byte-stream link from the register dump streamer to a UART TX or host link.
// A byte moves on a clock edge where tx_valid and tx_ready are both high.
interface reg_dump_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// On a halt rising edge, snapshots the cycle counter and streams a framed, checksummed dump
// of registers FirstReg..LastReg as bytes over a valid/ready link.
module reg_dump_streamer #(
  parameter int unsigned FirstReg = 1,
  parameter int unsigned LastReg  = 31,
  parameter logic [7:0]  Header   = 8'hA5,
  parameter logic [7:0]  Trailer  = 8'h5A
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       halt_i,
  input  logic [31:0]                cycle_count_i,
  output logic [4:0]                 rf_raddr_o,
  input  logic [31:0]                rf_rdata_i,
  reg_dump_streamer_if.master        tx_if,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [4:0] FirstIdx = 5'(FirstReg);
  localparam logic [4:0] LastIdx  = 5'(LastReg);

  typedef enum logic [2:0] {
    StIdle, StHdr, StCyc, StLoad, StIdx, StData, StSum, StTrl
  } state_e;

  state_e      state_q;
  logic [1:0]  beat_q;
  logic [31:0] shift_q;
  logic [7:0]  sum_q;
  logic [4:0]  cur_q;
  logic [4:0]  raddr_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic        halt_q;
  logic        xfer;

  assign xfer            = valid_q & tx_if.tx_ready;
  assign tx_if.tx_data   = data_q;
  assign tx_if.tx_valid  = valid_q;
  assign rf_raddr_o      = raddr_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      shift_q <= 32'd0;
      sum_q   <= 8'd0;
      cur_q   <= FirstIdx;
      raddr_q <= FirstIdx;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      halt_q <= halt_i;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Edges arriving mid-frame are dropped: halt_q tracks halt_i all the time.
          if (halt_i && !halt_q) begin
            shift_q <= cycle_count_i;
            raddr_q <= FirstIdx;
            sum_q   <= 8'd0;
            data_q  <= Header;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StHdr;
          end
        end
        StHdr, StIdx: begin
          if (xfer) begin
            sum_q   <= sum_q + data_q;
            data_q  <= shift_q[7:0];
            shift_q <= shift_q >> 8;
            beat_q  <= 2'd0;
            state_q <= (state_q == StHdr) ? StCyc : StData;
          end
        end
        StCyc: begin
          if (xfer) begin
            sum_q <= sum_q + data_q;
            if (beat_q == 2'd3) begin
              valid_q <= 1'b0;
              state_q <= StLoad;
            end else begin
              data_q  <= shift_q[7:0];
              shift_q <= shift_q >> 8;
              beat_q  <= beat_q + 2'd1;
            end
          end
        end
        StLoad: begin
          // raddr_q has been stable for a cycle, so rf_rdata_i is valid here.
          shift_q <= rf_rdata_i;
          cur_q   <= raddr_q;
          data_q  <= {3'b000, raddr_q};
          valid_q <= 1'b1;
          if (raddr_q != LastIdx) raddr_q <= raddr_q + 5'd1;
          state_q <= StIdx;
        end
        StData: begin
          if (xfer) begin
            sum_q <= sum_q + data_q;
            if (beat_q == 2'd3) begin
              if (cur_q == LastIdx) begin
                data_q  <= sum_q + data_q;
                state_q <= StSum;
              end else begin
                valid_q <= 1'b0;
                state_q <= StLoad;
              end
            end else begin
              data_q  <= shift_q[7:0];
              shift_q <= shift_q >> 8;
              beat_q  <= beat_q + 2'd1;
            end
          end
        end
        StSum: begin
          if (xfer) begin
            data_q  <= Trailer;
            state_q <= StTrl;
          end
        end
        StTrl: begin
          if (xfer) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: frames are compared against a byte list built from the
// frame-format rules, plus fixed-byte tables, stall stability, reset and re-trigger cases.
module tb_reg_dump_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [31:0] cycle_count;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy;
  logic        done;

  reg_dump_streamer_if bus ();

  reg_dump_streamer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .halt_i        (halt),
    .cycle_count_i (cycle_count),
    .rf_raddr_o    (rf_raddr),
    .rf_rdata_i    (rf_rdata),
    .tx_if         (bus),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  logic [31:0] tick = 32'd0;
  logic [31:0] base = 32'd0;
  always @(posedge clk) tick <= tick + 32'd1;
  assign cycle_count = base + tick;

  // 0: always ready, 1: ~30% ready, 2: never ready
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ($urandom_range(0, 9) < 3);
      default: bus.tx_ready = 1'b0;
    endcase
  end

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   done_cnt = 0;
  int   stall_cnt = 0;
  int   stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cnt++;
        if (!bus.tx_valid || bus.tx_data != prev_data) stall_viol++;
      end
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (done) done_cnt++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame from the format rules: header, LE snapshot, {idx, LE data} per reg, sum, trailer.
  task automatic build_exp(input logic [31:0] snap);
    int sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((snap >> (8 * i)) & 32'hFF));
    for (int r = 1; r <= 31; r++) begin
      exp_q.push_back(8'(r));
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((rf[r] >> (8 * i)) & 32'hFF));
    end
    sum = 0;
    foreach (exp_q[i]) sum += int'(exp_q[i]);
    exp_q.push_back(8'(sum % 256));
    exp_q.push_back(8'h5A);
  endtask

  task automatic compare_frame(input string name, input logic [31:0] snap);
    int bad;
    int first;
    build_exp(snap);
    check({name, "_len"}, 64'(got_q.size()), 64'(162));
    bad = 0;
    first = -1;
    foreach (exp_q[i]) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0 && first < got_q.size())
      check({name, "_bytes"}, 64'(got_q[first]), 64'(exp_q[first]));
    else
      check({name, "_bytes_bad"}, 64'(bad), 64'(0));
  endtask

  // Raise halt, optionally pulse it low at byte pulse_at, wait for done, check the frame.
  task automatic run_frame(input string name, input logic [31:0] snap, input int mode,
                           input bit check_lat, input int pulse_at);
    int n;
    int d0;
    bit pulsed;
    got_q.delete();
    stall_cnt  = 0;
    stall_viol = 0;
    d0 = done_cnt;
    rdy_mode = mode;
    @(posedge clk);
    #1;
    base = snap - tick;
    halt = 1'b1;
    n = 0;
    pulsed = 1'b0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) base = 32'hDEAD_0000;
      if (!halt) halt = 1'b1;
      if (pulse_at > 0 && !pulsed && got_q.size() >= pulse_at) begin
        halt = 1'b0;
        pulsed = 1'b1;
      end
      if (done) break;
    end
    check({name, "_done_seen"}, 64'(done), 64'(1));
    if (check_lat) check({name, "_latency"}, 64'(n), 64'(194));
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, {62'd0, done, busy}, 64'(0));
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'(1));
    check({name, "_stall_viol"}, 64'(stall_viol), 64'(0));
    if (mode == 1) check({name, "_stalls_seen"}, 64'(stall_cnt > 0), 64'(1));
    compare_frame(name, snap);
  endtask

  task automatic rearm();
    halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         scen;
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int scen, input int pos, input logic [7:0] exp);
    vec_t v;
    v.scen = scen;
    v.pos  = pos;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic apply_vecs(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        if (vecs[i].pos < got_q.size())
          check($sformatf("s%0d_byte%0d", scen, vecs[i].pos), 64'(got_q[vecs[i].pos]),
                64'(vecs[i].exp));
        else
          check($sformatf("s%0d_byte%0d_present", scen, vecs[i].pos), 64'(got_q.size()),
                64'(vecs[i].pos + 1));
      end
    end
  endtask

  initial begin
    logic [7:0] s2_bytes [15];
    logic [7:0] s4_bytes [15];
    int         s4_pos   [15];
    logic [31:0] snap;
    int sum;
    int n;
    int d0;

    s2_bytes = '{8'hA5, 8'h23, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h10,
                 8'h02, 8'h02, 8'h00, 8'h00, 8'h10};
    s4_bytes = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 8'h0A, 8'h00, 8'h00, 8'h00,
                 8'h09, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
    s4_pos   = '{15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 45, 46, 47, 48, 49};
    for (int i = 0; i < 15; i++) add_vec(2, i, s2_bytes[i]);
    for (int i = 0; i < 15; i++) add_vec(4, s4_pos[i], s4_bytes[i]);

    // 1: reset and idle
    rst_n = 1'b0;
    halt  = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[0] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {52'd0, bus.tx_valid, bus.tx_data, busy, done, 1'b0},
          64'd0);
    check("reset_raddr", 64'(rf_raddr), 64'(1));
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_quiet", {61'd0, bus.tx_valid, busy, done}, 64'd0);
    end
    check("idle_raddr", 64'(rf_raddr), 64'(1));

    // 2: full-rate frame
    run_frame("s2", 32'h0000_0123, 0, 1'b1, 0);
    apply_vecs(2);
    rearm();

    // 3: same contents under back-pressure
    run_frame("s3", 32'h0000_0123, 1, 1'b0, 0);
    rearm();

    // 4: sign-extended and small values, independent checksum
    rf[9] = 32'hFFFF_FFF8;
    rf[3] = 32'd5;
    rf[4] = 32'd10;
    run_frame("s4", 32'h89AB_CDEF, 0, 1'b1, 0);
    apply_vecs(4);
    sum = 0;
    for (int i = 0; i < 160 && i < got_q.size(); i++) sum += int'(got_q[i]);
    if (got_q.size() > 160) check("s4_checksum", 64'(got_q[160]), 64'(sum % 256));
    else check("s4_checksum_present", 64'(got_q.size()), 64'(162));
    rearm();

    // Random contents and snapshots
    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_frame($sformatf("rand%0d", k), $urandom, int'($urandom_range(0, 1)), 1'b0, 0);
      rearm();
    end

    // 5: halt glitch mid-frame is ignored, then a clean edge re-triggers
    d0 = done_cnt;
    run_frame("s5", 32'h0000_0555, 0, 1'b1, 50);
    repeat (250) @(posedge clk);
    #1;
    check("s5_no_second_frame", 64'(got_q.size()), 64'(162));
    check("s5_single_done", 64'(done_cnt - d0), 64'(1));
    rearm();
    run_frame("s5_rearm", 32'h0000_0AAA, 0, 1'b1, 0);
    rearm();

    // 6: reset during a stalled byte, halt held high across release
    got_q.delete();
    rdy_mode = 0;
    halt = 1'b1;
    n = 0;
    while (got_q.size() < 80 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("s6_reached_80", 64'(got_q.size() >= 80), 64'(1));
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    check("s6_stalled_valid", 64'(bus.tx_valid), 64'(1));
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_drop", {62'd0, bus.tx_valid, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("s6_no_done", 64'(done_cnt - d0), 64'(0));
    check("s6_raddr_reset", 64'(rf_raddr), 64'(1));
    got_q.delete();
    stall_viol = 0;
    rst_n = 1'b1;
    rdy_mode = 0;
    snap = cycle_count;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("s6_done_seen", 64'(done), 64'(1));
    check("s6_latency", 64'(n), 64'(194));
    @(posedge clk);
    #1;
    compare_frame("s6", snap);
    check("s6_stall_viol", 64'(stall_viol), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
